// File: rtl/tag_pkg.sv
// Shared tag-space definitions for the rename table, dispatcher and free-tag list.
package tag_pkg;
    localparam int TAG_W = 6;
    localparam int DEPTH = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Single-step pointer increment with explicit wrap, so DEPTH need not be a power of two.
    function automatic int ptr_step(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction
endpackage

// File: rtl/tag_freelist_mp_prefix_rank.sv
// Combinational prefix popcount: exclusive rank of each set bit, total count,
// and the length of the leading run of ones starting at bit 0.
module prefix_rank #(
    parameter int  N  = 2,
    localparam int RW = $clog2(N + 1)
) (
    input  logic [N-1:0]         i_bits,
    output logic [N-1:0][RW-1:0] o_rank,
    output logic [RW-1:0]        o_count,
    output logic [RW-1:0]        o_lead
);
    logic [RW-1:0] w_cnt;
    logic [RW-1:0] w_lead;
    logic          w_run;

    always_comb begin
        w_cnt  = '0;
        w_lead = '0;
        w_run  = 1'b1;
        o_rank = '0;
        for (int i = 0; i < N; i++) begin
            o_rank[i] = w_cnt;
            w_cnt     = w_cnt + RW'(i_bits[i]);
            w_run     = w_run & i_bits[i];
            w_lead    = w_lead + RW'(w_run);
        end
        o_count = w_cnt;
        o_lead  = w_lead;
    end
endmodule

// File: rtl/tag_freelist_mp.sv
// Multi-port free physical-tag list: circular buffer preloaded with every tag,
// FWFT allocation on POP_PORTS ports, compacted returns on PUSH_PORTS ports.
module tag_freelist_mp #(
    parameter int  TAG_W      = tag_pkg::TAG_W,
    parameter int  DEPTH      = tag_pkg::DEPTH,
    parameter int  POP_PORTS  = 2,
    parameter int  PUSH_PORTS = 2,
    parameter int  LOW_THRESH = 4,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [POP_PORTS-1:0]        pop_req,
    output logic [POP_PORTS*TAG_W-1:0]  pop_tag,
    output logic [POP_PORTS-1:0]        pop_avail,
    input  logic [PUSH_PORTS-1:0]       push_valid,
    input  logic [PUSH_PORTS*TAG_W-1:0] push_tag,
    output logic [CW-1:0]               free_count,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic                        free_low,
    output logic                        err_overflow,
    output logic                        err_underflow
);
    import tag_pkg::*;

    localparam int PW  = $clog2(DEPTH);
    localparam int PRW = $clog2(POP_PORTS + 1);
    localparam int URW = $clog2(PUSH_PORTS + 1);

    logic [TAG_W-1:0] r_entry [DEPTH];
    logic [PW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;
    logic             r_full, r_empty, r_low, r_err_ovf, r_err_udf;

    logic [POP_PORTS-1:0]            w_pop_ok;
    logic [PRW-1:0]                  w_npop;
    logic [POP_PORTS-1:0][PRW-1:0]   w_pop_rank_unused;
    logic [PRW-1:0]                  w_pop_cnt_unused;
    logic                            w_udf;
    logic [PUSH_PORTS-1:0][URW-1:0]  w_push_rank;
    logic [URW-1:0]                  w_push_cnt;
    logic [URW-1:0]                  w_push_lead_unused;
    logic [PUSH_PORTS-1:0]           w_push_acc;
    logic [PUSH_PORTS-1:0][PW-1:0]   w_push_idx;
    int                              w_space, w_npush;
    logic                            w_ovf;
    logic [PW-1:0]                   w_head_nxt, w_tail_nxt;
    logic [CW-1:0]                   w_count_nxt;

    // Advance a pointer by n (n <= 4) one wrap-checked step at a time.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        logic [PW-1:0] q;
        q = p;
        for (int k = 0; k < 4; k++)
            if (k < n) q = PW'(ptr_step(int'(q), DEPTH));
        return q;
    endfunction

    always_comb begin
        pop_tag   = '0;
        pop_avail = '0;
        for (int i = 0; i < POP_PORTS; i++) begin
            pop_tag[i*TAG_W +: TAG_W] = r_entry[ptr_add(r_head, i)];
            pop_avail[i]              = int'(r_count) > i;
        end
    end

    assign w_pop_ok = pop_req & pop_avail;
    assign w_udf    = |(pop_req & ~pop_avail);

    prefix_rank #(.N(POP_PORTS)) u_pop_rank (
        .i_bits  (w_pop_ok),
        .o_rank  (w_pop_rank_unused),
        .o_count (w_pop_cnt_unused),
        .o_lead  (w_npop)
    );

    prefix_rank #(.N(PUSH_PORTS)) u_push_rank (
        .i_bits  (push_valid),
        .o_rank  (w_push_rank),
        .o_count (w_push_cnt),
        .o_lead  (w_push_lead_unused)
    );

    // Slots freed by this cycle's pops are usable by this cycle's pushes.
    always_comb begin
        w_space     = DEPTH - int'(r_count) + int'(w_npop);
        w_npush     = (int'(w_push_cnt) < w_space) ? int'(w_push_cnt) : w_space;
        w_ovf       = int'(w_push_cnt) > w_space;
        w_push_acc  = '0;
        w_push_idx  = '0;
        for (int k = 0; k < PUSH_PORTS; k++) begin
            w_push_acc[k] = push_valid[k] && (int'(w_push_rank[k]) < w_space);
            w_push_idx[k] = ptr_add(r_tail, int'(w_push_rank[k]));
        end
        w_head_nxt  = ptr_add(r_head, int'(w_npop));
        w_tail_nxt  = ptr_add(r_tail, w_npush);
        w_count_nxt = CW'(int'(r_count) - int'(w_npop) + w_npush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_entry[i] <= TAG_W'(i);
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= CW'(DEPTH);
            r_full    <= 1'b1;
            r_empty   <= 1'b0;
            r_low     <= (DEPTH < LOW_THRESH);
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            for (int k = 0; k < PUSH_PORTS; k++)
                if (w_push_acc[k]) r_entry[w_push_idx[k]] <= push_tag[k*TAG_W +: TAG_W];
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_count   <= w_count_nxt;
            r_full    <= int'(w_count_nxt) == DEPTH;
            r_empty   <= w_count_nxt == '0;
            r_low     <= int'(w_count_nxt) < LOW_THRESH;
            r_err_ovf <= r_err_ovf | w_ovf;
            r_err_udf <= r_err_udf | w_udf;
        end
    end

    assign free_count    = r_count;
    assign fifo_full     = r_full;
    assign fifo_empty    = r_empty;
    assign free_low      = r_low;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_udf;
endmodule

// File: tb/tb_tag_freelist_mp.sv
// Directed bench: a 64-tag list for drain/refill/overflow sequences and a 6-tag
// list driven from a vector table for pointer wrap and simultaneous push/pop.
module tb_tag_freelist_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0]  a_pop_req, a_pop_avail, a_push_valid;
    logic [11:0] a_pop_tag, a_push_tag;
    logic [6:0]  a_count;
    logic        a_full, a_empty, a_low, a_ovf, a_udf;

    logic [1:0]  b_pop_req, b_pop_avail, b_push_valid;
    logic [5:0]  b_pop_tag, b_push_tag;
    logic [2:0]  b_count;
    logic        b_full, b_empty, b_low, b_ovf, b_udf;

    tag_freelist_mp #(.TAG_W(6), .DEPTH(64), .POP_PORTS(2), .PUSH_PORTS(2), .LOW_THRESH(4)) dut_a (
        .clk(clk), .rst(rst), .pop_req(a_pop_req), .pop_tag(a_pop_tag), .pop_avail(a_pop_avail),
        .push_valid(a_push_valid), .push_tag(a_push_tag), .free_count(a_count),
        .fifo_full(a_full), .fifo_empty(a_empty), .free_low(a_low),
        .err_overflow(a_ovf), .err_underflow(a_udf)
    );

    tag_freelist_mp #(.TAG_W(3), .DEPTH(6), .POP_PORTS(2), .PUSH_PORTS(2), .LOW_THRESH(4)) dut_b (
        .clk(clk), .rst(rst), .pop_req(b_pop_req), .pop_tag(b_pop_tag), .pop_avail(b_pop_avail),
        .push_valid(b_push_valid), .push_tag(b_push_tag), .free_count(b_count),
        .fifo_full(b_full), .fifo_empty(b_empty), .free_low(b_low),
        .err_overflow(b_ovf), .err_underflow(b_udf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] pop;
        logic [1:0] pv;
        logic [2:0] pt0, pt1;
        int         cnt;
        int         t0, t1;
        logic [1:0] tchk;
        logic       udf;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{2'b11, 2'b00, 3'd0, 3'd0, 4, 2, 3, 2'b11, 1'b0};
        vt[1]  = '{2'b11, 2'b00, 3'd0, 3'd0, 2, 4, 5, 2'b11, 1'b0};
        vt[2]  = '{2'b01, 2'b00, 3'd0, 3'd0, 1, 5, 0, 2'b01, 1'b0};
        vt[3]  = '{2'b00, 2'b11, 3'd7, 3'd6, 3, 5, 7, 2'b11, 1'b0};
        vt[4]  = '{2'b00, 2'b11, 3'd2, 3'd1, 5, 5, 7, 2'b11, 1'b0};
        vt[5]  = '{2'b11, 2'b00, 3'd0, 3'd0, 3, 6, 2, 2'b11, 1'b0};
        vt[6]  = '{2'b11, 2'b00, 3'd0, 3'd0, 1, 1, 0, 2'b01, 1'b0};
        vt[7]  = '{2'b01, 2'b11, 3'd4, 3'd0, 2, 4, 0, 2'b11, 1'b0};
        vt[8]  = '{2'b00, 2'b01, 3'd3, 3'd0, 3, 4, 0, 2'b11, 1'b0};
        vt[9]  = '{2'b11, 2'b00, 3'd0, 3'd0, 1, 3, 0, 2'b01, 1'b0};
        vt[10] = '{2'b10, 2'b00, 3'd0, 3'd0, 1, 3, 0, 2'b01, 1'b1};
        vt[11] = '{2'b11, 2'b00, 3'd0, 3'd0, 0, 0, 0, 2'b00, 1'b1};
        vt[12] = '{2'b00, 2'b11, 3'd5, 3'd6, 2, 5, 6, 2'b11, 1'b1};

        rst = 1'b1;
        a_pop_req = '0; a_push_valid = '0; a_push_tag = '0;
        b_pop_req = '0; b_push_valid = '0; b_push_tag = '0;
        step(); step();
        rst = 1'b0;

        chk("a_rst_count", a_count, 64);
        chk("a_rst_full", a_full, 1);
        chk("a_rst_empty", a_empty, 0);
        chk("a_rst_low", a_low, 0);
        chk("a_rst_tag0", a_pop_tag[5:0], 0);
        chk("a_rst_tag1", a_pop_tag[11:6], 1);
        chk("a_rst_avail", a_pop_avail, 2'b11);
        chk("a_rst_ovf", a_ovf, 0);
        chk("a_rst_udf", a_udf, 0);
        chk("b_rst_count", b_count, 6);
        chk("b_rst_full", b_full, 1);
        chk("b_rst_tag1", b_pop_tag[5:3], 1);

        // Drain all 64 tags two per cycle, in order.
        a_pop_req = 2'b11;
        for (int c = 0; c < 32; c++) begin
            chk("a_drain_tag0", a_pop_tag[5:0], 2 * c);
            chk("a_drain_tag1", a_pop_tag[11:6], 2 * c + 1);
            step();
        end
        a_pop_req = 2'b00;
        chk("a_empty_count", a_count, 0);
        chk("a_empty_flag", a_empty, 1);
        chk("a_empty_full", a_full, 0);
        chk("a_empty_avail", a_pop_avail, 2'b00);
        chk("a_empty_low", a_low, 1);
        chk("a_empty_udf", a_udf, 0);

        // Return 5 on port 1 alone, then 9 and 3; compaction keeps port order.
        a_push_valid = 2'b10; a_push_tag = {6'd5, 6'd0};
        step();
        a_push_valid = 2'b11; a_push_tag = {6'd3, 6'd9};
        step();
        a_push_valid = 2'b00;
        chk("a_ret_tag0", a_pop_tag[5:0], 5);
        chk("a_ret_tag1", a_pop_tag[11:6], 9);
        chk("a_ret_count", a_count, 3);
        chk("a_ret_low", a_low, 1);

        a_pop_req = 2'b10;
        step();
        a_pop_req = 2'b00;
        chk("a_gap_count", a_count, 3);
        chk("a_gap_udf", a_udf, 0);
        chk("a_gap_tag0", a_pop_tag[5:0], 5);

        // Refill to full.
        for (int c = 0; c < 30; c++) begin
            a_push_valid = 2'b11;
            a_push_tag   = {6'(c + 30), 6'(c)};
            step();
        end
        a_push_valid = 2'b01; a_push_tag = {6'd0, 6'd60};
        step();
        a_push_valid = 2'b00;
        chk("a_full_count", a_count, 64);
        chk("a_full_flag", a_full, 1);
        chk("a_full_low", a_low, 0);
        chk("a_full_tag0", a_pop_tag[5:0], 5);

        // Full: a same-cycle pop makes room for the push.
        a_push_valid = 2'b01; a_push_tag = {6'd0, 6'd40}; a_pop_req = 2'b01;
        step();
        a_push_valid = 2'b00; a_pop_req = 2'b00;
        chk("a_swap_count", a_count, 64);
        chk("a_swap_ovf", a_ovf, 0);
        chk("a_swap_tag0", a_pop_tag[5:0], 9);
        chk("a_swap_tag1", a_pop_tag[11:6], 3);

        // Full with no pop: push is dropped and the sticky flag sets.
        a_push_valid = 2'b01; a_push_tag = {6'd0, 6'd41};
        step();
        a_push_valid = 2'b00;
        chk("a_drop_ovf", a_ovf, 1);
        chk("a_drop_count", a_count, 64);
        step();
        chk("a_drop_ovf_sticky", a_ovf, 1);
        chk("a_drop_tag0", a_pop_tag[5:0], 9);

        // Six-entry list: wrap of head and tail, simultaneous push/pop, underflow.
        for (int v = 0; v < 13; v++) begin
            b_pop_req    = vt[v].pop;
            b_push_valid = vt[v].pv;
            b_push_tag   = {vt[v].pt1, vt[v].pt0};
            step();
            chk($sformatf("b_v%0d_count", v), b_count, vt[v].cnt);
            chk($sformatf("b_v%0d_avail", v), b_pop_avail, {vt[v].cnt > 1, vt[v].cnt > 0});
            chk($sformatf("b_v%0d_full", v), b_full, vt[v].cnt == 6);
            chk($sformatf("b_v%0d_empty", v), b_empty, vt[v].cnt == 0);
            chk($sformatf("b_v%0d_low", v), b_low, vt[v].cnt < 4);
            chk($sformatf("b_v%0d_udf", v), b_udf, vt[v].udf);
            chk($sformatf("b_v%0d_ovf", v), b_ovf, 0);
            if (vt[v].tchk[0]) chk($sformatf("b_v%0d_tag0", v), b_pop_tag[2:0], vt[v].t0);
            if (vt[v].tchk[1]) chk($sformatf("b_v%0d_tag1", v), b_pop_tag[5:3], vt[v].t1);
        end
        b_pop_req = 2'b00; b_push_valid = 2'b00;

        // Reset overrides an active pop request.
        a_pop_req = 2'b11; b_pop_req = 2'b11;
        rst = 1'b1;
        step();
        chk("b_rrst_count", b_count, 6);
        chk("b_rrst_full", b_full, 1);
        chk("b_rrst_empty", b_empty, 0);
        chk("b_rrst_low", b_low, 0);
        chk("b_rrst_tag0", b_pop_tag[2:0], 0);
        chk("b_rrst_tag1", b_pop_tag[5:3], 1);
        chk("b_rrst_avail", b_pop_avail, 2'b11);
        chk("b_rrst_udf", b_udf, 0);
        chk("b_rrst_ovf", b_ovf, 0);
        chk("a_rrst_count", a_count, 64);
        chk("a_rrst_ovf", a_ovf, 0);
        chk("a_rrst_tag0", a_pop_tag[5:0], 0);
        rst = 1'b0; a_pop_req = 2'b00; b_pop_req = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
